// File: rtl/apb_master_nslv_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
// Shared types and helpers for the N-slave APB master:
//   state_e     - master FSM states (IDLE / SETUP / ACCESS)
//   err_code_e  - reason a completed transfer reports err
//   idx_w()     - width of the slave index field (minimum 1)
//   cnt_w()     - width of the ACCESS-phase wait counter (minimum 8)
// ---------------------------------------------------------------------------
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_code_e;

    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// ---------------------------------------------------------------------------
// apb_master_nslv_if
// APB bus bundle between the master and NUM_SLAVES slaves.
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL : master -> slaves
//   PRDATA (packed, slave i at [i*DATA_W +: DATA_W]) / PREADY : slaves -> master
// Modports: master, slave.
// ---------------------------------------------------------------------------
interface apb_master_nslv_if #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic                         PWRITE;
    logic                         PENABLE;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_nslv_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational address decode for the APB master.
//   addr_i : request address
//   idx_o  : slave index, addr_i[REGION_SHIFT +: IDX_W]
//   hit_o  : upper bits match BASE_ADDR and idx_o < NUM_SLAVES
// ---------------------------------------------------------------------------
module apb_addr_decoder
    import apb_master_pkg::*;
#(
    parameter int unsigned       NUM_SLAVES   = 8,
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned       REGION_SHIFT = 12,
    parameter int unsigned       IDX_W        = idx_w(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              hit_o
);
    // Bits above the index field must match the peripheral window base.
    localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << (REGION_SHIFT + IDX_W);
    localparam logic [IDX_W:0]    NS      = (IDX_W + 1)'(NUM_SLAVES);

    assign idx_o = addr_i[REGION_SHIFT +: IDX_W];
    assign hit_o = (((addr_i ^ BASE_ADDR) & HI_MASK) == '0) && ({1'b0, idx_o} < NS);

endmodule

// File: rtl/apb_master_nslv.sv
// ---------------------------------------------------------------------------
// apb_master_nslv
// Core request/ready interface to APB SETUP/ACCESS phases for NUM_SLAVES
// slaves, with err on unmapped addresses.
// Optional feature macro: APB_TIMEOUT_EN - when defined, an ACCESS phase that
// waits TIMEOUT_CYCLES cycles without PREADY completes with err=1.
// Ports:
//   PCLK, PRESET (async, active-low)
//   transfer/write/addr/wdata : core request
//   rdata/ready/err           : completion (ready is a one-cycle pulse)
//   apb                       : APB master modport (PADDR..PREADY)
// ---------------------------------------------------------------------------
module apb_master_nslv
    import apb_master_pkg::*;
#(
    parameter int unsigned       NUM_SLAVES     = 8,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned       REGION_SHIFT   = 12,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              transfer,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    apb_master_nslv_if.master apb
);
    localparam int unsigned IDX_W = idx_w(NUM_SLAVES);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hit_q, hit_d;

    logic [IDX_W-1:0]    req_idx;
    logic                req_hit;

    logic [NUM_SLAVES-1:0] psel_dec;
    logic                  pready_sel;
    logic [DATA_W-1:0]     prdata_sel;
    logic                  psel_en;
    logic                  penable;
    logic                  timeout;
    err_code_e             err_code;

    apb_addr_decoder #(
        .NUM_SLAVES   (NUM_SLAVES),
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_SHIFT (REGION_SHIFT),
        .IDX_W        (IDX_W)
    ) u_dec (
        .addr_i (addr),
        .idx_o  (req_idx),
        .hit_o  (req_hit)
    );

    // One-hot select of the latched slave; PREADY/PRDATA of other slaves are masked.
    always_comb begin
        psel_dec   = '0;
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            psel_dec[i] = hit_q && (32'(idx_q) == i);
            if (psel_dec[i]) begin
                pready_sel = apb.PREADY[i];
                prdata_sel = apb.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned      CNT_W    = cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds the number of stalled ACCESS cycles already seen, so the
    // TIMEOUT_CYCLES-th stalled cycle is the one that completes.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready_sel) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == ACCESS) && !pready_sel && (cnt_q >= CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        ready    = 1'b0;
        rdata    = '0;
        err_code = ERR_NONE;
        psel_en  = 1'b0;
        penable  = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel_en = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_en = 1'b1;
                penable = 1'b1;
                // PREADY is checked before the timeout so a same-cycle ready wins.
                if (!hit_q) begin
                    ready    = 1'b1;
                    err_code = ERR_UNMAPPED;
                end else if (pready_sel) begin
                    ready = 1'b1;
                    rdata = prdata_sel;
                end else if (timeout) begin
                    ready    = 1'b1;
                    err_code = ERR_TIMEOUT;
                end
                if (ready) begin
                    state_d = transfer ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request is accepted only when idle or in the completing cycle.
        if (transfer && ((state_q == IDLE) || ready)) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
            idx_d    = req_idx;
            hit_d    = req_hit;
        end
    end

    assign err = (err_code != ERR_NONE);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
        end
    end

    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PENABLE = penable;
    assign apb.PSEL    = psel_en ? psel_dec : '0;

endmodule

// File: tb/tb_apb_master_nslv.sv
// ---------------------------------------------------------------------------
// tb_apb_master_nslv
// Directed bench for apb_master_nslv (8 slaves, 4 KB regions at 0x1000_0000,
// TIMEOUT_CYCLES=4). Inputs change 1 ns after PCLK rise; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_master_nslv;

    localparam int unsigned NS = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          transfer;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NS*DW-1:0] prd;
    logic [AW-1:0]    paddr_hold;

    apb_master_nslv_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_master_nslv #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .BASE_ADDR      (32'h1000_0000),
        .REGION_SHIFT   (12),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .apb      (apb)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
    endtask

    initial begin
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        for (int i = 0; i < NS; i++) prd[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);
        prd[6*DW +: DW] = 32'h0000_00A5;
        apb.PRDATA = prd;
        apb.PREADY = '1;

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check_val("rst_psel",    64'(apb.PSEL),    64'h0);
        check_val("rst_penable", 64'(apb.PENABLE), 64'h0);
        check_val("rst_paddr",   64'(apb.PADDR),   64'h0);
        check_val("rst_ready",   64'(ready),       64'h0);
        check_val("rst_err",     64'(err),         64'h0);
        check_val("rst_rdata",   64'(rdata),       64'h0);
        tick();
        PRESET = 1'b1;
        tick();

        // 1. Write to slave 1, zero wait states
        req(1'b1, 32'h1000_1004, 32'hDEAD_BEEF);
        @(negedge PCLK);
        check_val("wr_n_ready", 64'(ready), 64'h0);
        tick();
        transfer = 1'b0;
        @(negedge PCLK);
        check_val("wr_setup_psel",    64'(apb.PSEL),    64'h02);
        check_val("wr_setup_penable", 64'(apb.PENABLE), 64'h0);
        check_val("wr_setup_pwrite",  64'(apb.PWRITE),  64'h1);
        check_val("wr_setup_ready",   64'(ready),       64'h0);
        tick();
        @(negedge PCLK);
        check_val("wr_acc_penable", 64'(apb.PENABLE), 64'h1);
        check_val("wr_acc_psel",    64'(apb.PSEL),    64'h02);
        check_val("wr_acc_ready",   64'(ready),       64'h1);
        check_val("wr_acc_err",     64'(err),         64'h0);
        check_val("wr_pwdata",      64'(apb.PWDATA),  64'hDEAD_BEEF);
        check_val("wr_paddr",       64'(apb.PADDR),   64'h1000_1004);
        tick();
        @(negedge PCLK);
        check_val("wr_idle_psel",    64'(apb.PSEL),    64'h0);
        check_val("wr_idle_penable", 64'(apb.PENABLE), 64'h0);
        check_val("wr_idle_ready",   64'(ready),       64'h0);
        tick();

        // 2. Read from slave 6 with three wait states
        apb.PREADY[6] = 1'b0;
        req(1'b0, 32'h1000_6000, 32'h0);
        tick();
        transfer = 1'b0;
        @(negedge PCLK);
        check_val("rd_setup_psel", 64'(apb.PSEL), 64'h40);
        paddr_hold = 32'h1000_6000;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge PCLK);
            check_val("rd_wait_ready",   64'(ready),       64'h0);
            check_val("rd_wait_penable", 64'(apb.PENABLE), 64'h1);
            check_val("rd_wait_paddr",   64'(apb.PADDR),   64'(paddr_hold));
            check_val("rd_wait_psel",    64'(apb.PSEL),    64'h40);
        end
        tick();
        apb.PREADY[6] = 1'b1;
        @(negedge PCLK);
        check_val("rd_ready", 64'(ready), 64'h1);
        check_val("rd_rdata", 64'(rdata), 64'hA5);
        check_val("rd_err",   64'(err),   64'h0);
        check_val("rd_pwrite", 64'(apb.PWRITE), 64'h0);
        tick();
        @(negedge PCLK);
        check_val("rd_after_ready", 64'(ready), 64'h0);
        tick();

        // 3. Unmapped: outside window, and index 8 (above the index field)
        for (int u = 0; u < 2; u++) begin
            req(1'b0, (u == 0) ? 32'h2000_0000 : 32'h1000_8000, 32'h0);
            tick();
            transfer = 1'b0;
            @(negedge PCLK);
            check_val("um_setup_psel",  64'(apb.PSEL), 64'h0);
            check_val("um_setup_ready", 64'(ready),    64'h0);
            tick();
            @(negedge PCLK);
            check_val("um_ready", 64'(ready),    64'h1);
            check_val("um_err",   64'(err),      64'h1);
            check_val("um_rdata", 64'(rdata),    64'h0);
            check_val("um_psel",  64'(apb.PSEL), 64'h0);
            tick();
            @(negedge PCLK);
            check_val("um_after_ready", 64'(ready), 64'h0);
            tick();
        end

        // 4. Back-to-back, plus a transfer pulsed during SETUP
        req(1'b1, 32'h1000_1000, 32'h1111_2222);
        tick();
        transfer = 1'b0;
        tick();
        req(1'b1, 32'h1000_2000, 32'h3333_4444);
        @(negedge PCLK);
        check_val("b2b_first_ready", 64'(ready), 64'h1);
        tick();
        req(1'b1, 32'h1000_5000, 32'h5555_6666);
        @(negedge PCLK);
        check_val("b2b_setup_psel",    64'(apb.PSEL),    64'h04);
        check_val("b2b_setup_penable", 64'(apb.PENABLE), 64'h0);
        check_val("b2b_setup_paddr",   64'(apb.PADDR),   64'h1000_2000);
        check_val("b2b_setup_ready",   64'(ready),       64'h0);
        tick();
        transfer = 1'b0;
        @(negedge PCLK);
        check_val("b2b_second_ready", 64'(ready),      64'h1);
        check_val("b2b_second_paddr", 64'(apb.PADDR),  64'h1000_2000);
        check_val("b2b_second_wdata", 64'(apb.PWDATA), 64'h3333_4444);
        tick();
        @(negedge PCLK);
        check_val("b2b_ignored_psel",    64'(apb.PSEL),    64'h0);
        check_val("b2b_ignored_penable", 64'(apb.PENABLE), 64'h0);
        tick();

        // 5. Reset asserted during ACCESS
        apb.PREADY[3] = 1'b0;
        req(1'b0, 32'h1000_3000, 32'h0);
        tick();
        transfer = 1'b0;
        tick();
        @(negedge PCLK);
        check_val("rst_pre_penable", 64'(apb.PENABLE), 64'h1);
        check_val("rst_pre_psel",    64'(apb.PSEL),    64'h08);
        #2;
        PRESET = 1'b0;
        #1;
        check_val("rst_async_psel",    64'(apb.PSEL),    64'h0);
        check_val("rst_async_penable", 64'(apb.PENABLE), 64'h0);
        check_val("rst_async_ready",   64'(ready),       64'h0);
        check_val("rst_async_paddr",   64'(apb.PADDR),   64'h0);
        tick();
        PRESET = 1'b1;
        apb.PREADY[3] = 1'b1;
        @(negedge PCLK);
        check_val("rst_rel_psel",    64'(apb.PSEL),    64'h0);
        check_val("rst_rel_penable", 64'(apb.PENABLE), 64'h0);
        check_val("rst_rel_ready",   64'(ready),       64'h0);
        tick();
        req(1'b0, 32'h1000_1008, 32'h0);
        tick();
        transfer = 1'b0;
        tick();
        @(negedge PCLK);
        check_val("rst_idle_ready", 64'(ready), 64'h1);
        check_val("rst_idle_rdata", 64'(rdata), 64'hC0DE_0001);
        tick();

`ifdef APB_TIMEOUT_EN
        // 6. Hung slave 3 times out after 4 ACCESS cycles; then PREADY on the timeout cycle
        for (int r = 0; r < 2; r++) begin
            apb.PREADY[3] = 1'b0;
            req(1'b0, 32'h1000_3000, 32'h0);
            tick();
            transfer = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                @(negedge PCLK);
                check_val("to_wait_ready", 64'(ready), 64'h0);
            end
            tick();
            if (r == 1) apb.PREADY[3] = 1'b1;
            @(negedge PCLK);
            check_val("to_ready", 64'(ready), 64'h1);
            check_val("to_err",   64'(err),   (r == 0) ? 64'h1 : 64'h0);
            check_val("to_rdata", 64'(rdata), (r == 0) ? 64'h0 : 64'hC0DE_0003);
            tick();
            @(negedge PCLK);
            check_val("to_after_psel",    64'(apb.PSEL),    64'h0);
            check_val("to_after_penable", 64'(apb.PENABLE), 64'h0);
            tick();
        end
        apb.PREADY[3] = 1'b1;
`else
        // 6. Without the timeout a hung slave stalls; releasing PREADY completes it
        apb.PREADY[3] = 1'b0;
        req(1'b0, 32'h1000_3000, 32'h0);
        tick();
        transfer = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge PCLK);
            check_val("hang_ready",   64'(ready),       64'h0);
            check_val("hang_penable", 64'(apb.PENABLE), 64'h1);
        end
        tick();
        apb.PREADY[3] = 1'b1;
        @(negedge PCLK);
        check_val("hang_release_ready", 64'(ready), 64'h1);
        check_val("hang_release_err",   64'(err),   64'h0);
        check_val("hang_release_rdata", 64'(rdata), 64'hC0DE_0003);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
Parametrised successor to the fixed 8-slave APB master between the RV32I core data port and the peripheral bus. It converts the core's transfer/ready request interface into APB SETUP/ACCESS phases. It decodes the address to one of NUM_SLAVES one-hot PSEL lines and muxes PRDATA/PREADY back. Unlike the fixed-slave master, it also signals an error (err) on unmapped addresses and, optionally, on a hung slave.

Parameters:
NUM_SLAVES, 8, number of APB slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
BASE_ADDR, 32'h1000_0000, peripheral window base; bits above the index field must match
REGION_SHIFT, 12, log2 of bytes per slave region (4 KB)
TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN

Ports:
PCLK  in  1  bus clock
PRESET  in  1  asynchronous active-low reset
transfer  in  1  core request strobe, sampled when idle or completing
write  in  1  1 = write, 0 = read
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid while ready=1
ready  out  1  transfer complete, one-cycle pulse
err  out  1  error qualifier, valid while ready=1
PADDR  out  ADDR_W  latched address
PWDATA  out  DATA_W  latched write data
PWRITE  out  1  latched direction
PENABLE  out  1  ACCESS-phase indicator
PSEL  out  NUM_SLAVES  one-hot slave select
PRDATA  in  NUM_SLAVES*DATA_W  packed slave read data; slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready

Behaviour:
- Clock and reset: one clock (PCLK). Reset (PRESET) is asynchronous and active-low. While reset is asserted: state=IDLE; PADDR, PWDATA, PWRITE, PENABLE and PSEL are all 0; ready=0, err=0, rdata=0.
- Index field: IDX_W = clog2(NUM_SLAVES), minimum 1. idx = addr[REGION_SHIFT +: IDX_W].
- Address hit: the request hits when addr[ADDR_W-1 : REGION_SHIFT+IDX_W] equals the same bits of BASE_ADDR, and idx < NUM_SLAVES. Any other address is unmapped.
- IDLE: when transfer=1, latch addr/wdata/write into PADDR/PWDATA/PWRITE, latch idx and a hit flag, then go to SETUP. When transfer=0, stay in IDLE.
- SETUP (1 cycle): PSEL[idx]=hit and PENABLE=0. Always go to ACCESS.
- ACCESS: PSEL held and PENABLE=1.
  - Hit with PREADY[idx]=1: ready=1, err=0, rdata = PRDATA slice idx (combinational, same cycle).
  - Unmapped: no PSEL bit is set; complete in the first ACCESS cycle with ready=1, err=1, rdata=0.
  - PREADY[idx]=0: stay in ACCESS; PADDR/PWDATA/PWRITE/PSEL stay stable.
- Completion cycle: if transfer=1, latch the new request and go to SETUP (back-to-back; PSEL/PENABLE drop for the SETUP cycle). Otherwise go to IDLE, and PSEL=0, PENABLE=0 next cycle.
- Minimum latency: transfer at cycle N gives ready at N+2.
- transfer while busy (SETUP, or ACCESS that is not completing) is ignored; the master does not queue requests.
- PREADY of non-selected slaves is ignored. PSEL is never multi-hot.
- Reset asserted mid-transfer: immediately aborts to IDLE; no ready pulse is generated.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter clears on entering ACCESS and increments each ACCESS cycle while PREADY[idx]=0. When the count reaches TIMEOUT_CYCLES with PREADY still 0, the master completes with ready=1, err=1, rdata=0. PSEL/PENABLE are released as in a normal completion. If PREADY and the timeout occur in the same cycle, PREADY wins (err=0).
- Undefined: no counter; a hung slave stalls the bus indefinitely.

Decomposition:
- Package apb_master_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - localparam functions for IDX_W
  - err-code constants
- Sub-module apb_addr_decoder: purely combinational; outputs idx and hit from addr, BASE_ADDR, REGION_SHIFT and NUM_SLAVES. It is instantiated once in front of the latch registers.

Test Plan:
1. Write: addr=0x1000_1004, wdata=0xDEAD_BEEF, slave 1 PREADY tied 1 -> PSEL=0b0000_0010. PENABLE=0 in the cycle after transfer and 1 the next cycle. ready and PWDATA=0xDEAD_BEEF appear 2 cycles after transfer, err=0.
2. Read: addr=0x1000_6000, PRDATA slice 6=0x0000_00A5, PREADY[6] held 0 for 3 ACCESS cycles -> ready after 5 cycles with rdata=0xA5. PADDR is stable throughout.
3. Unmapped: addr=0x2000_0000 and addr=0x1000_8000 (NUM_SLAVES=8) -> PSEL stays 0; ready=1, err=1, rdata=0 at cycle N+2.
4. Back-to-back: a second transfer (addr=0x1000_2000) asserted in the completion cycle of the first -> SETUP for slave 2 in the next cycle with no IDLE gap. A transfer pulsed mid-SETUP is ignored.
5. Reset: PRESET dropped during ACCESS -> PSEL, PENABLE and ready are 0 asynchronously (before the next PCLK edge); after release, state is IDLE.
6. APB_TIMEOUT_EN with TIMEOUT_CYCLES=4: slave 3 never ready -> ready=1, err=1 after 4 ACCESS cycles. Repeat with PREADY rising on the timeout cycle -> err=0.
